// File: rtl/sa_result_drain.sv
// Collects a spatial-array column's output stream, which cannot be back-pressured, into a FIFO.
// Re-emits it as a valid/ready stream with a frame-last marker and flags any dropped samples.
module sa_result_drain #(
    parameter  int DATA_WIDTH    = 16,
    parameter  int FIFO_DEPTH    = 8,
    parameter  int FRAME_LEN_MAX = 256,
    localparam int LEN_W         = $clog2(FRAME_LEN_MAX) + 1,
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH:0]  mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]     level_reg, level_next;
    logic [LEN_W-1:0]     count_reg, count_next;
    logic                 overflow_reg, overflow_next;

    logic                 empty, full, pop, accept, drop;
    logic [LEN_W-1:0]     eff_len;
    logic                 in_last;
    logic [DATA_WIDTH:0]  head;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == LVL_W'(FIFO_DEPTH));

    // flush dominates both sides: nothing is popped, stored or counted as dropped
    assign pop    = !empty && out_ready && !flush;
    assign accept = in_valid && (!full || pop) && !flush;
    assign drop   = in_valid && full && !pop && !flush;

    assign eff_len = (frame_len == '0) ? LEN_W'(1) : frame_len;
    assign in_last = (count_reg >= eff_len - LEN_W'(1));

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg | drop;
        if (accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            count_next  = in_last ? '0 : count_reg + LEN_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
        if (flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            level_next    = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are meaningful
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem_reg[wr_ptr_reg] <= {in_last, in_data};
        end
    end

    assign head      = mem_reg[rd_ptr_reg];
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : head[DATA_WIDTH-1:0];
    assign out_last  = !empty && head[DATA_WIDTH];
    assign level     = level_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: hand-computed vectors plus a small queue
// model for the random-backpressure stretch.
module tb_sa_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic [8:0]  frame_len;
    logic        flush;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [3:0]  level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    sa_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .frame_len (frame_len),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
    endtask

    logic [16:0] q[$];
    int          mcnt;
    logic        movf;
    logic        mpop, maccept;
    logic        prev_valid, prev_ready;
    logic [15:0] prev_data;
    logic        prev_last;
    int          exp_last[5] = '{1, 0, 1, 0, 1};

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; frame_len = 9'd3;
        flush = 1'b0; out_ready = 1'b0;
        cycle(); cycle();
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_data", 32'(out_data), 0);
        rst = 1'b0;

        // three samples, frame of 3, pass straight through
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h3C00; cycle();
        check("t1_d0", 32'(out_data), 32'h3C00);
        check("t1_l0", 32'(out_last), 0);
        check("t1_lvl0", 32'(level), 1);
        in_data = 16'h4000; cycle();
        check("t1_d1", 32'(out_data), 32'h4000);
        check("t1_l1", 32'(out_last), 0);
        in_data = 16'h4200; cycle();
        check("t1_d2", 32'(out_data), 32'h4200);
        check("t1_l2", 32'(out_last), 1);
        in_valid = 1'b0; cycle();
        check("t1_lvl_end", 32'(level), 0);
        check("t1_valid_end", 32'(out_valid), 0);
        check("t1_data_end", 32'(out_data), 0);

        // fill to 8, one more is dropped, drain in order
        do_flush();
        frame_len = 9'd256; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'h0100 + 16'(i); cycle();
        end
        check("t2_lvl_full", 32'(level), 8);
        check("t2_ovf_before", 32'(overflow), 0);
        in_data = 16'h01FF; cycle();
        check("t2_lvl_drop", 32'(level), 8);
        check("t2_ovf_after", 32'(overflow), 1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_drain%0d", i), 32'(out_data), 32'h0100 + i);
            cycle();
        end
        check("t2_lvl_empty", 32'(level), 0);
        check("t2_ovf_sticky", 32'(overflow), 1);

        // full FIFO with simultaneous push and pop
        do_flush();
        check("t3_ovf_cleared", 32'(overflow), 0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'h0200 + 16'(i); cycle();
        end
        in_data = 16'h02FF; out_ready = 1'b1; cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        check("t3_lvl", 32'(level), 8);
        check("t3_ovf", 32'(overflow), 0);
        check("t3_head", 32'(out_data), 32'h0201);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) cycle();
        check("t3_tail", 32'(out_data), 32'h02FF);
        cycle();
        check("t3_lvl_end", 32'(level), 0);

        // frame length lowered mid-frame
        do_flush();
        out_ready = 1'b1; frame_len = 9'd4;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'h0300 + 16'(i); cycle();
            check($sformatf("t4_last%0d", i), 32'(out_last), 0);
        end
        frame_len = 9'd2;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h0303 + 16'(i); cycle();
            check($sformatf("t4_last%0d", i + 3), 32'(out_last), 32'(exp_last[i]));
        end

        // zero frame length: every sample closes a frame
        frame_len = 9'd0;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'h0400 + 16'(i); cycle();
            check($sformatf("t5_last%0d", i), 32'(out_last), 1);
        end
        in_valid = 1'b0; cycle();

        // flush coincident with a valid input while 5 entries held
        do_flush();
        out_ready = 1'b0; frame_len = 9'd8;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'h0600 + 16'(i); cycle();
        end
        check("t6_lvl5", 32'(level), 5);
        in_data = 16'h06AA; flush = 1'b1; out_ready = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("t6_lvl", 32'(level), 0);
        check("t6_valid", 32'(out_valid), 0);
        check("t6_ovf", 32'(overflow), 0);
        in_valid = 1'b1; in_data = 16'h0655; cycle();
        in_valid = 1'b0;
        check("t6_next_data", 32'(out_data), 32'h0655);
        check("t6_next_lvl", 32'(level), 1);

        // reset asserted mid-stream
        in_valid = 1'b1; in_data = 16'h0700; cycle();
        rst = 1'b1; in_data = 16'h0701; cycle();
        rst = 1'b0; in_valid = 1'b0;
        check("t8_lvl", 32'(level), 0);
        check("t8_valid", 32'(out_valid), 0);
        check("t8_data", 32'(out_data), 0);

        // random backpressure against a continuous stream, checked against a queue model
        do_flush();
        frame_len = 9'd5; mcnt = 0; movf = 1'b0; q.delete();
        for (int i = 0; i < 80; i++) begin
            in_valid   = 1'b1;
            in_data    = 16'h0500 + 16'(i);
            out_ready  = 1'($urandom_range(0, 1));
            mpop       = (q.size() != 0) && out_ready;
            maccept    = (q.size() < 8) || mpop;
            prev_valid = out_valid; prev_ready = out_ready;
            prev_data  = out_data;  prev_last  = out_last;
            cycle();
            if (mpop) void'(q.pop_front());
            if (maccept) begin
                q.push_back({(mcnt >= 4), in_data});
                mcnt = (mcnt >= 4) ? 0 : mcnt + 1;
            end else begin
                movf = 1'b1;
            end
            check($sformatf("t7_lvl%0d", i), 32'(level), 32'(q.size()));
            check($sformatf("t7_ovf%0d", i), 32'(overflow), 32'(movf));
            if (q.size() != 0) begin
                check($sformatf("t7_data%0d", i), 32'(out_data), 32'(q[0][15:0]));
                check($sformatf("t7_last%0d", i), 32'(out_last), 32'(q[0][16]));
            end
            if (prev_valid && !prev_ready) begin
                check($sformatf("t7_hold%0d", i), 32'({out_last, out_data}), 32'({prev_last, prev_data}));
            end
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
